// File: rtl/mem_arbiter_if.sv
// Cache-side request channels and byte-wide RAM/IO bus of the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IC_BYTES   = 4
);
  // instruction-fetch channel
  logic                    ic_req;
  logic [ADDR_WIDTH-1:0]   ic_addr;
  logic                    ic_done;
  logic [8*IC_BYTES-1:0]   ic_data;
  // load/store channel
  logic                    ls_req;
  logic                    ls_wr;
  logic [ADDR_WIDTH-1:0]   ls_addr;
  logic [1:0]              ls_size;
  logic [31:0]             ls_wdata;
  logic                    ls_done;
  logic [31:0]             ls_rdata;
  // RAM/IO bus
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  modport slave (
    input  ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between ICache fetches and LSB loads/stores on a
// single-port byte-wide RAM/IO bus. LS has priority; one byte per cycle.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    IC_BYTES   = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BOUND   = 32'h30000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rdy,
  input  logic i_clr,
  mem_arbiter_if.slave bus
);
  // counters must hold 0..IC_BYTES inclusive
  localparam int CW = $clog2(IC_BYTES + 1);

  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_nxt;     // byte index currently on mem_a
  logic [CW-1:0]              r_cap;     // first byte not yet captured
  logic [CW-1:0]              r_len;     // bytes in this transfer
  logic                       r_vld;     // mem_din this cycle answers an issued byte
  logic                       r_wr;      // write pending on the bus
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [ADDR_WIDTH-1:0]      r_mem_a;
  logic [7:0]                 r_mem_dout;
  logic                       r_ic_done;
  logic                       r_ls_done;
  logic [IC_BYTES-1:0][7:0]   r_buf;
  logic [IC_BYTES-1:0][7:0]   r_ic_data;
  logic [31:0]                r_ls_rdata;

  logic [CW-1:0]              w_ls_len;
  logic [CW-1:0]              w_nxt1;
  logic [IC_BYTES-1:0][7:0]   w_line;
  logic [31:0]                w_ls_line;
  logic                       w_stall;
  logic                       w_fin;
  logic                       w_accept;

  // decode LS access size; 11 behaves as a word
  always_comb begin
    case (bus.ls_size)
      2'b00:   w_ls_len = CW'(1);
      2'b01:   w_ls_len = CW'(2);
      default: w_ls_len = CW'(4);
    endcase
  end

  // line as it looks once the byte on mem_din is merged in; LS view zero-extended
  always_comb begin
    w_line = r_buf;
    for (int k = 0; k < IC_BYTES; k++)
      if (CW'(k) == r_cap) w_line[k] = bus.mem_din;
    w_ls_line = '0;
    for (int k = 0; k < 4; k++)
      if (CW'(k) < r_len) w_ls_line[8*k +: 8] = w_line[k];
  end

  assign w_nxt1   = r_nxt + CW'(1);
  assign w_fin    = r_vld && (r_cap == r_len - CW'(1));
  assign w_stall  = bus.io_buffer_full && (r_mem_a >= IO_BOUND);
  assign w_accept = !i_clr && !r_ic_done && !r_ls_done;

  // a pending write is suppressed while paused or while the IO buffer is full
  assign bus.mem_wr   = r_wr && i_rdy && !w_stall;
  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.ic_done  = r_ic_done;
  assign bus.ic_data  = r_ic_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

  // arbitration FSM with issue/capture counters and registered bus outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_nxt      <= '0;
      r_cap      <= '0;
      r_len      <= '0;
      r_vld      <= 1'b0;
      r_wr       <= 1'b0;
      r_base     <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_ic_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_buf      <= '0;
      r_ic_data  <= '0;
      r_ls_rdata <= '0;
    end else begin
      // done pulses are single-cycle even across a pause
      r_ic_done <= 1'b0;
      r_ls_done <= 1'b0;
      if (i_rdy) begin
        unique case (r_state)
          IDLE: if (w_accept && (bus.ls_req || bus.ic_req)) begin
            r_nxt <= '0;
            r_cap <= '0;
            r_vld <= 1'b0;
            if (bus.ls_req) begin
              r_base  <= bus.ls_addr;
              r_mem_a <= bus.ls_addr;
              r_len   <= w_ls_len;
              if (bus.ls_wr) begin
                r_state    <= LS_WR;
                r_wr       <= 1'b1;
                r_mem_dout <= bus.ls_wdata[7:0];
              end else begin
                r_state <= LS_RD;
              end
            end else begin
              r_base  <= bus.ic_addr;
              r_mem_a <= bus.ic_addr;
              r_len   <= CW'(IC_BYTES);
              r_state <= IC_RD;
            end
          end
          IC_RD, LS_RD: begin
            if (i_clr) begin
              r_state <= IDLE;
              r_vld   <= 1'b0;
              r_mem_a <= '0;
            end else if (w_fin) begin
              r_state <= IDLE;
              r_vld   <= 1'b0;
              r_mem_a <= '0;
              r_buf   <= w_line;
              if (r_state == IC_RD) begin
                r_ic_data <= w_line;
                r_ic_done <= 1'b1;
              end else begin
                r_ls_rdata <= w_ls_line;
                r_ls_done  <= 1'b1;
              end
            end else begin
              if (r_vld) begin
                r_buf <= w_line;
                r_cap <= r_cap + CW'(1);
              end
              r_vld <= (r_nxt < r_len);
              if (r_nxt < r_len) begin
                r_nxt   <= w_nxt1;
                // park the bus at 0 once every byte is issued
                r_mem_a <= (w_nxt1 < r_len) ? r_base + ADDR_WIDTH'(w_nxt1) : '0;
              end
            end
          end
          LS_WR: if (!w_stall) begin
            if (r_nxt == r_len - CW'(1)) begin
              r_state   <= IDLE;
              r_wr      <= 1'b0;
              r_mem_a   <= '0;
              r_ls_done <= 1'b1;
            end else begin
              r_nxt      <= w_nxt1;
              r_mem_a    <= r_base + ADDR_WIDTH'(w_nxt1);
              r_mem_dout <= bus.ls_wdata[{w_nxt1[1:0], 3'b000} +: 8];
            end
          end
        endcase
      end else if (r_state == IC_RD || r_state == LS_RD) begin
        // paused: data in flight is lost, so rewind the bus to the first uncaptured byte
        r_vld   <= 1'b0;
        r_nxt   <= r_cap;
        r_mem_a <= r_base + ADDR_WIDTH'(r_cap);
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised byte-serial memory controller between the CPU's caches and the single-port, byte-wide RAM/IO bus. It arbitrates between an instruction-fetch channel (ICache, configurable line size) and a load/store channel (LSB, 1/2/4-byte reads and writes), sequences one RAM byte per cycle, and honours IO-buffer back-pressure on IO writes. It supports flush on mispredict and freezes cleanly on `rdy` low.

## Interface
- `ADDR_WIDTH`, 32, address width of all address ports.
- `IC_BYTES`, 4, bytes per ICache fetch (power of 2, 4..64).
- `IO_BOUND`, 32'h30000, addresses >= this are IO space.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low = pause.
- `clr` in 1: flush (branch mispredict).
- `mem_din` in 8: RAM read data (1-cycle read latency).
- `mem_dout` out 8: RAM write data.
- `mem_a` out ADDR_WIDTH: RAM byte address.
- `mem_wr` out 1: 1 = write `mem_dout` to `mem_a` this cycle.
- `io_buffer_full` in 1: IO write buffer full.
- `ic_req` in 1, `ic_addr` in ADDR_WIDTH: fetch request (addr aligned to IC_BYTES).
- `ic_done` out 1: one-cycle completion pulse.
- `ic_data` out 8*IC_BYTES: fetched line, byte k at bits [8k+7:8k] = RAM[ic_addr+k].
- `ls_req` in 1, `ls_wr` in 1, `ls_addr` in ADDR_WIDTH, `ls_size` in 2 (00 byte, 01 half, 10 word, 11 illegal, treated as word), `ls_wdata` in 32.
- `ls_done` out 1: one-cycle completion pulse.
- `ls_rdata` out 32: load data, little-endian, zero-extended above the access size.

## Operation
- States: IDLE, IC_RD, LS_RD, LS_WR.
- IDLE accepts a request only if `rdy`=1, `clr`=0 and no done pulse is asserted this cycle. If both `ls_req` and `ic_req` are high, LS wins; IC waits.
- Requesters hold req/addr/data stable until their done pulse and drop req the cycle after.
- Read of N bytes (N = IC_BYTES or 1/2/4): issue counter drives `mem_a` = base+k, k=0..N-1, one per cycle. Capture counter stores `mem_din` one cycle later. After byte N-1 is captured, the FSM pulses done, updates the data output and returns to IDLE.
- Write of N bytes: each cycle drives `mem_a`=addr+k, `mem_dout`=`ls_wdata[8k+7:8k]`, `mem_wr`=1.
  - If `io_buffer_full`=1 and addr+k >= IO_BOUND, `mem_wr`=0 that cycle and byte k is retried.
  - Non-IO writes ignore `io_buffer_full`.
- Address arithmetic is modulo 2^ADDR_WIDTH. Misaligned LS accesses are legal.
- `clr`=1 in IC_RD or LS_RD: abort next edge, go to IDLE, no done pulse, data outputs unchanged.
- `clr`=1 in LS_WR: ignored; a committed store always completes.
- `clr` and a request in the same IDLE cycle: request ignored.
- `rdy`=0: all state holds and `mem_wr` is forced 0.
  - On resume, a read re-issues from the first uncaptured byte, because data returned during the pause is discarded.
  - On resume, a write re-issues its current byte.
- Outside LS_WR, `mem_wr`=0 and `mem_a`=0 in IDLE.

## Timing
- Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `ic_done`=0, `ls_done`=0, `ic_data`=0, `ls_rdata`=0, state IDLE, counters 0.
- Request sampled in cycle T:
  - Byte k is addressed in cycle T+1+k.
  - Byte k's data is captured at the end of T+2+k.
  - Read done is high in cycle T+N+2.
- Write done is high in cycle T+N+1, plus one cycle per IO stall and per `rdy`-low cycle.
- Done pulses last exactly 1 cycle. Data outputs hold their value until the next completion of the same channel.
- Minimum request-to-request spacing is N+3 cycles (read) or N+2 cycles (write).

## Test plan
- Reset, then IC fetch: `ic_addr`=0x100, RAM[0x100..0x103]=13,00,00,93 -> `ic_done` in T+6, `ic_data`=32'h93000013. `mem_a` steps 0x100..0x103 in T+1..T+4.
- LS byte load at 0x1003 (RAM=0xF0) -> `ls_done` at T+3, `ls_rdata`=32'h000000F0. Word store 0xDEADBEEF at 0x2000 -> writes EF,BE,AD,DE at 0x2000..0x2003, `ls_done` at T+5.
- Simultaneous `ic_req`/`ls_req` in the same cycle -> LS served first. IC starts the cycle after `ls_done`+1 and completes correctly.
- Byte store to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` low for those 3 cycles, then one write. `ls_done` 3 cycles late. The same store to 0x1000 is not stalled.
- `clr` in the 3rd cycle of IC_RD -> no `ic_done`, `ic_data` unchanged, IDLE next cycle. `clr` during a word store -> all 4 bytes written and `ls_done` pulses.
- `rdy` low for 2 cycles mid IC fetch (IC_BYTES=16) -> `mem_wr`=0 throughout, fetch resumes, `ic_data` matches RAM, completion delayed by 3 cycles.
